// File: rtl/star_pkg.sv
// Shared types and widths for the star collection / power-up logic.
package star_pkg;

  localparam int SCORE_W = 14;
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POWER = 2'd1,
    ST_WARN  = 2'd2
  } state_e;

endpackage

// File: rtl/game_tick_gen.sv
// Free-running game-tick prescaler: tick is high while the count sits at TICK_DIV-1.
module game_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic sys_clk,
  input  logic RST_N,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pres_q;
  logic [PW-1:0] pres_d;

  always_comb begin
    pres_d = pres_q + 1'b1;
    if (clr || (pres_q == LAST)) pres_d = '0;
  end

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) pres_q <= '0;
    else        pres_q <= pres_d;
  end

  assign tick = (pres_q == LAST);

endmodule

// File: rtl/star_collect_ctrl.sv
// Edge-detects sticky star touch levels, keeps score / star count, and runs
// the invincibility timer (POWER -> WARN -> IDLE). dbg_* expose the FSM.
module star_collect_ctrl
  import star_pkg::*;
#(
  parameter int NUM_STARS       = 4,
  parameter int POINTS_PER_STAR = 10,
  parameter int SCORE_MAX       = 9999,
  parameter int TICK_DIV        = 833333,
  parameter int POWER_TICKS     = 300,
  parameter int WARN_TICKS      = 90
) (
  input  logic                 sys_clk,
  input  logic                 RST_N,
  input  logic [NUM_STARS-1:0] touch_star,
  input  logic                 game_restart,
  output logic [SCORE_W-1:0]   score,
  output logic [COUNT_W-1:0]   star_count,
  output logic                 collect_pulse,
  output logic                 invincible,
  output logic                 blink,
  output logic                 all_collected,
  output logic [1:0]           dbg_state_o,
  output logic [8:0]           dbg_timer_o
);

  logic [NUM_STARS-1:0] prev_q;
  logic [NUM_STARS-1:0] rise;
  logic [15:0]          k;
  logic                 collect;
  logic                 tick;
  logic [15:0]          score_sum, score_sat, count_sum, count_sat;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 pulse_q, invincible_q, blink_q;
  state_e               state_q, state_d;
  logic [8:0]           timer_q, timer_d, timer_dec;

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sys_clk (sys_clk),
    .RST_N   (RST_N),
    .clr     (game_restart),
    .tick    (tick)
  );

  assign rise = touch_star & ~prev_q;

  always_comb begin
    k = '0;
    for (int i = 0; i < NUM_STARS; i++) k = k + 16'(rise[i]);
  end

  assign collect   = (k != 16'd0);
  assign score_sum = 16'(score_q) + k * 16'(POINTS_PER_STAR);
  assign score_sat = (score_sum > 16'(SCORE_MAX)) ? 16'(SCORE_MAX) : score_sum;
  assign score_d   = SCORE_W'(score_sat);
  assign count_sum = 16'(count_q) + k;
  assign count_sat = (count_sum > 16'd15) ? 16'd15 : count_sum;
  assign count_d   = COUNT_W'(count_sat);
  assign timer_dec = timer_q - 9'd1;

  // Restart beats collect, and collect beats any tick/expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (game_restart) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else if (collect) begin
      state_d = ST_POWER;
      timer_d = 9'(POWER_TICKS);
    end else if (tick) begin
      case (state_q)
        ST_POWER: begin
          timer_d = timer_dec;
          if (timer_dec <= 9'(WARN_TICKS)) state_d = ST_WARN;
        end
        ST_WARN: begin
          timer_d = timer_dec;
          if (timer_dec == 9'd0) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      prev_q       <= '0;
      score_q      <= '0;
      count_q      <= '0;
      pulse_q      <= 1'b0;
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      invincible_q <= 1'b0;
      blink_q      <= 1'b0;
    end else begin
      prev_q       <= touch_star;
      state_q      <= state_d;
      timer_q      <= timer_d;
      invincible_q <= (state_d != ST_IDLE);
      blink_q      <= (state_d == ST_WARN) & timer_d[2];
      if (game_restart) begin
        score_q <= '0;
        count_q <= '0;
        pulse_q <= 1'b0;
      end else if (collect) begin
        score_q <= score_d;
        count_q <= count_d;
        pulse_q <= 1'b1;
      end else begin
        pulse_q <= 1'b0;
      end
    end
  end

  assign score         = score_q;
  assign star_count    = count_q;
  assign collect_pulse = pulse_q;
  assign invincible    = invincible_q;
  assign blink         = blink_q;
  assign all_collected = (16'(count_q) >= 16'(NUM_STARS));
  assign dbg_state_o   = state_q;
  assign dbg_timer_o   = timer_q;

endmodule
